// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit 4-bit codes from a multiplexed active-low anode/segment bus.
// Optional decimal-point capture is enabled with `define SEG7_DP_EN.
module seg7_scan_decoder #(
  parameter int unsigned N_DIG         = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned TIMEOUT       = 1_000_000
) (
  input  logic                 C50,
  input  logic                 Rst,
  input  logic [N_DIG-1:0]     Anodo,
  input  logic [6:0]           D,
`ifdef SEG7_DP_EN
  input  logic                 DP,
  output logic [N_DIG-1:0]     Punto,
`endif
  output logic [4*N_DIG-1:0]   Codigo,
  output logic [N_DIG-1:0]     Valido,
  output logic                 Nuevo,
  output logic                 ErrPat,
  output logic                 Conflicto
);

  localparam int unsigned IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
`ifdef SEG7_DP_EN
  localparam int unsigned SW = IW + 8;
`else
  localparam int unsigned SW = IW + 7;
`endif

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: return {1'b1, 4'h0};
      7'b1001111: return {1'b1, 4'h1};
      7'b0010010: return {1'b1, 4'h2};
      7'b0000110: return {1'b1, 4'h3};
      7'b1001100: return {1'b1, 4'h4};
      7'b0100100: return {1'b1, 4'h5};
      7'b0100000: return {1'b1, 4'h6};
      7'b0001111: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0000100: return {1'b1, 4'h9};
      7'b1111110: return {1'b1, 4'hA};
      7'b1111111: return {1'b1, 4'hF};
      default:    return {1'b0, 4'hF};
    endcase
  endfunction

  logic [N_DIG-1:0] an_s1, an_s2;
  logic [6:0]       d_s1, d_s2;
`ifdef SEG7_DP_EN
  logic             dp_s1, dp_s2;
`endif

  always_ff @(posedge C50) begin
    if (Rst) begin
      an_s1 <= '1;
      an_s2 <= '1;
      d_s1  <= '1;
      d_s2  <= '1;
    end else begin
      an_s1 <= Anodo;
      an_s2 <= an_s1;
      d_s1  <= D;
      d_s2  <= d_s1;
    end
  end

`ifdef SEG7_DP_EN
  always_ff @(posedge C50) begin
    if (Rst) begin
      dp_s1 <= 1'b1;
      dp_s2 <= 1'b1;
    end else begin
      dp_s1 <= DP;
      dp_s2 <= dp_s1;
    end
  end
`endif

  logic [1:0]    nlow;
  logic [IW-1:0] cur_idx;
  logic [SW-1:0] cur_samp;
  logic          single, multi, same;

  // Low-anode count saturates at 2: only none/one/many matter.
  always_comb begin
    nlow    = '0;
    cur_idx = '0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (!an_s2[i]) begin
        if (nlow != 2'd2) nlow = nlow + 2'd1;
        cur_idx = IW'(i);
      end
    end
  end

`ifdef SEG7_DP_EN
  assign cur_samp = {cur_idx, d_s2, dp_s2};
`else
  assign cur_samp = {cur_idx, d_s2};
`endif

  logic [1:0]    state, state_n;
  logic [SW-1:0] samp, samp_n;
  logic [7:0]    cnt, cnt_n;
  logic          multi_q;
  logic          hit;

  assign single = (nlow == 2'd1);
  assign multi  = (nlow == 2'd2);
  assign same   = single && (cur_samp == samp);

  always_comb begin
    state_n = state;
    samp_n  = samp;
    cnt_n   = cnt;
    hit     = 1'b0;
    case (state)
      IDLE: begin
        if (single) begin
          samp_n  = cur_samp;
          cnt_n   = 8'd1;
          state_n = TRACK;
        end
      end
      TRACK: begin
        if (same) begin
          cnt_n = cnt + 8'd1;
          if (cnt_n == 8'(STABLE_CYCLES)) begin
            hit     = 1'b1;
            state_n = LOCKED;
          end
        end else if (single) begin
          samp_n = cur_samp;
          cnt_n  = 8'd1;
        end else begin
          state_n = IDLE;
        end
      end
      LOCKED: begin
        if (!same) begin
          if (single) begin
            samp_n  = cur_samp;
            cnt_n   = 8'd1;
            state_n = TRACK;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A hit never changes samp, so the stored sample names the digit being committed.
  logic [IW-1:0] s_idx;
  logic [6:0]    s_d;
  logic [4:0]    dec;
  logic [3:0]    old_code;
  logic          commit, errp;

  assign s_idx    = samp[SW-1 -: IW];
  assign s_d      = samp[SW-IW-1 -: 7];
  assign dec      = decode(s_d);
  assign commit   = hit & dec[4];
  assign errp     = hit & ~dec[4];
  assign old_code = Codigo[4*s_idx +: 4];

  logic [TW-1:0] tcnt [N_DIG];

  always_ff @(posedge C50) begin
    if (Rst) begin
      state     <= IDLE;
      samp      <= '0;
      cnt       <= '0;
      multi_q   <= 1'b0;
      Codigo    <= '1;
      Valido    <= '0;
      Nuevo     <= 1'b0;
      ErrPat    <= 1'b0;
      Conflicto <= 1'b0;
`ifdef SEG7_DP_EN
      Punto     <= '0;
`endif
      for (int unsigned i = 0; i < N_DIG; i++) tcnt[i] <= '0;
    end else begin
      state     <= state_n;
      samp      <= samp_n;
      cnt       <= cnt_n;
      multi_q   <= multi;
      Conflicto <= multi & ~multi_q;
      ErrPat    <= errp;
      Nuevo     <= commit && (old_code != dec[3:0]);
      // Commit takes priority over a timeout landing on the same digit.
      for (int unsigned i = 0; i < N_DIG; i++) begin
        if (commit && (s_idx == IW'(i))) begin
          tcnt[i]          <= '0;
          Valido[i]        <= 1'b1;
          Codigo[4*i +: 4] <= dec[3:0];
`ifdef SEG7_DP_EN
          Punto[i]         <= ~samp[0];
`endif
        end else if (tcnt[i] != TW'(TIMEOUT)) begin
          tcnt[i] <= tcnt[i] + 1'b1;
          if (tcnt[i] == TW'(TIMEOUT - 1)) Valido[i] <= 1'b0;
        end else begin
          Valido[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the team's 7-segment display drivers. Monitors a multiplexed, active-low anode/segment bus and recovers the value shown on each digit position as a 4-bit code.
- Used on loopback boards and in self-check harnesses to read back what a display driver is showing.
- Deglitches scan transitions, rejects unknown patterns and reports per-digit staleness.

Parameters:
- N_DIG, 4, number of digit positions (anode lines).
- STABLE_CYCLES, 8, consecutive identical samples required before a digit value is committed; legal range 2..255.
- TIMEOUT, 1_000_000, C50 cycles without a commit on a digit before that digit's valid bit clears (20 ms at 50 MHz).

Ports:
- C50  input  1  system clock, 50 MHz; all logic is on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- Anodo  input  N_DIG  anode enables, active-low; bit i selects digit i.
- D  input  7  segment lines, active-low; bit6=a … bit0=g.
- Codigo  output  4*N_DIG  committed code per digit; digit i occupies bits [4i+3:4i].
- Valido  output  N_DIG  bit i=1 while digit i holds a fresh committed value.
- Nuevo  output  1  one-cycle pulse when any committed code changes value.
- ErrPat  output  1  one-cycle pulse when a stable pattern is not in the decode table.
- Conflicto  output  1  one-cycle pulse on the first cycle that more than one anode is low.

Behaviour:
- Reset, synchronous, active-high. On a C50 edge with Rst=1: Codigo=all 4'hF, Valido=0, Nuevo=0, ErrPat=0, Conflicto=0, FSM=IDLE, all counters=0. Reset overrides any in-progress track or lock.
- Input sampling: Anodo and D pass through a 2-flop synchronizer. All decisions below use the synchronized values, so input-to-output latency is 2 cycles plus the stability window.
- Decode table (D active-low, value -> code):
  - 0000001 -> 0
  - 1001111 -> 1
  - 0010010 -> 2
  - 0000110 -> 3
  - 1001100 -> 4
  - 0100100 -> 5
  - 0100000 -> 6
  - 0001111 -> 7
  - 0000000 -> 8
  - 0000100 -> 9
  - 1111110 -> A (dash)
  - 1111111 -> F (blank)
  - Any other pattern is unknown.
- FSM states: IDLE, TRACK, LOCKED. The stored sample is {anode index, D}.
- IDLE:
  - Exactly one anode low: store sample, cnt=1, go to TRACK.
  - Zero anodes low: stay in IDLE.
  - More than one anode low: pulse Conflicto, stay in IDLE.
- TRACK:
  - Sample equals stored sample: cnt++.
  - When cnt reaches STABLE_CYCLES:
    - Known pattern: commit the code to digit idx, set Valido[idx], reload that digit's timeout counter.
    - Unknown pattern: pulse ErrPat; Codigo and Valido are left unchanged.
    - Either way, go to LOCKED.
  - Sample differs and exactly one anode is low: restore with the new sample, cnt=1.
  - Zero anodes low: go to IDLE.
  - Multiple anodes low: pulse Conflicto, go to IDLE.
- LOCKED:
  - Sample stays identical: no action; no re-commit or timeout reload until a new TRACK completes.
  - Any change: same exit rules as TRACK (new single-anode sample -> TRACK with cnt=1).
- Nuevo: asserted one cycle after the commit edge, only if the new code differs from the previous Codigo for that digit. Committing an identical value produces no pulse.
- Timeout: one counter per digit, saturating at TIMEOUT. On reaching TIMEOUT: clear Valido[i]; Codigo[i] is retained.
  - A commit and a timeout on the same digit in the same cycle: the commit wins.
- Conflicto: pulses once per entry into the multi-anode condition, not on every cycle it persists.
- Outputs are registered, with no combinational input-to-output path.

Optional Feature:
- Macro: SEG7_DP_EN.
- Defined:
  - Adds input DP (1 bit, active-low) and output Punto [N_DIG-1:0].
  - DP becomes part of the compared sample.
  - On commit, Punto[idx] = ~DP.
  - Punto resets to 0.
- Undefined: no DP port, no Punto port; behaviour exactly as above.

Test Plan:
- Rst held 3 cycles -> Codigo=16'hFFFF, Valido=4'b0000, all pulses 0.
- Anodo=4'b1110, D=7'b0010010 held 20 cycles -> Codigo[3:0]=2 and Valido[0]=1 committed 2+8 cycles after the first application; one Nuevo pulse.
- Scan all 4 digits with 0, 7, A, 9, 1000 cycles per digit, 4 loops -> Codigo=16'h9A70, Valido=4'hF; Nuevo pulses only on the first loop.
- D alternates between 5 and 6 every 4 cycles on digit 1 -> no commit, Codigo[7:4] unchanged; then D=5 held 8 cycles -> commit 5.
- Anodo=4'b1100 for 10 cycles -> single Conflicto pulse, no commit; D=7'b1010101 stable on digit 2 -> single ErrPat pulse, Valido[2] unchanged.
- After committing digit 3, hold Anodo=4'b1111 for TIMEOUT cycles -> Valido[3]=0, Codigo[15:12] retained; assert Rst mid-TRACK -> FSM returns to IDLE, no commit follows.
